imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader for the Async_RV32I core. It accepts a byte stream over a valid/ready handshake from a host-side link (UART/debug bridge) and assembles the bytes little-endian into `XLEN-bit words. It writes those words sequentially into the instruction memory through a synchronous write port, and holds the core in stall for the duration of the load. It sits between the host link, the core's fetch/stall control and the imem write port.

## Interface
- Parameters:
- TIMEOUT_CYC, 1_000_000: maximum idle cycles between accepted bytes during a load before the load aborts; minimum legal value 2.
- Ports:
- i_clk  input  1  single clock for the block.
- i_rst  input  1  reset; asynchronous, active-high.
- i_start  input  1  single-cycle pulse that starts a load; honoured only in IDLE.
- i_last_addr  input  `IMEM_ADDR_BIT-2  last word address to load; sampled when i_start is accepted.
- i_byte_valid  input  1  host byte valid.
- i_byte  input  8  host byte.
- o_byte_ready  output  1  loader can accept a byte.
- o_imem_we  output  1  imem write enable, one cycle per word.
- o_imem_waddr  output  `IMEM_ADDR_BIT-2  imem word address.
- o_imem_wdata  output  `XLEN  imem write data.
- o_core_hold  output  1  core stall/hold request.
- o_busy  output  1  load in progress.
- o_done  output  1  one-cycle pulse when a load completes.
- o_err  output  1  one-cycle pulse when a load aborts on timeout.

## Operation
- All outputs are registered. Reset values are 0 for every output, including o_imem_waddr and o_imem_wdata.
- The FSM has five states: IDLE, RECV, WRITE, DONE and ERR.
- IDLE
  - o_byte_ready is 0.
  - i_start=1 latches i_last_addr, clears the word address, byte index and timeout counter, then moves to RECV.
- RECV
  - o_byte_ready is 1.
  - A byte is accepted on i_byte_valid & o_byte_ready. It is placed into lane byte_idx (byte 0 goes to bits 7:0), and byte_idx increments.
  - Accepting byte_idx==3 moves to WRITE.
  - Every accepted byte resets the timeout counter. Otherwise the counter increments.
  - When the counter reaches TIMEOUT_CYC-1 with no byte accepted, the FSM moves to ERR.
- WRITE
  - o_imem_we=1 for exactly one cycle, with the assembled address and data.
  - o_byte_ready is 0.
  - If the address equals the latched last address, the FSM moves to DONE. Otherwise the address increments, byte_idx clears and the FSM returns to RECV.
- DONE: o_done=1 for one cycle, then IDLE.
- ERR: o_err=1 for one cycle, then IDLE.
  - The partial word is discarded and never written.
  - Words already written stay in memory.
- o_busy and o_core_hold are 1 in RECV, WRITE, DONE and ERR, and 0 in IDLE.
- i_start outside IDLE is ignored.
- The address arithmetic is `IMEM_ADDR_BIT-2 bits wide. Because the FSM stops at the latched last address, the address never wraps.
- i_last_addr = all ones loads the full imem depth.

## Timing
- The first byte can be accepted in the cycle after i_start.
- Per word: 4 accept cycles plus 1 WRITE cycle, so 5 cycles per word minimum at full host rate.
- o_imem_we is asserted in the cycle after the 4th byte is accepted.
- o_done is asserted in the cycle after the last WRITE. o_core_hold drops in the cycle after o_done.
- i_byte_valid asserted in the same cycle as i_start is not accepted, because ready is low in IDLE.
- i_rst mid-load: the FSM goes to IDLE asynchronously and all outputs go to 0. No write or done pulse is produced. imem contents are left as they are.
- The imem write is synchronous. The write port is added to instr_mem as i_clk, i_imem_we, i_imem_waddr and i_imem_wdata, and the existing asynchronous read port is unchanged.

## Structure
- The FSM state encodings and the byte-lane count (`XLEN/8) go in core/pkg.v. This block reuses `XLEN and `IMEM_ADDR_BIT from that file.
- One sub-module, imem_word_packer, contains the byte index, the lane shift register and a word_full flag. It is cleared by the FSM.
- The timeout counter is a $clog2(TIMEOUT_CYC)-bit counter inside imem_loader.

## Test plan
- Reset, then i_start with i_last_addr=0 and bytes 0x13,0x00,0x00,0x00. Expect one o_imem_we with addr 0 and data 0x00000013, then o_done, then o_core_hold=0.
- i_last_addr=3 with 16 back-to-back bytes. Expect 4 writes at addrs 0..3 in little-endian order, with 5 cycles between writes.
- Host stalls i_byte_valid for 2 cycles between bytes with TIMEOUT_CYC=8. Expect no abort and data written correctly.
- TIMEOUT_CYC=8 and 2 bytes sent, then silence. Expect o_err 8 cycles after the last accept, no write of the partial word, and return to IDLE.
- i_rst asserted during WRITE of word 1 of 3. Expect all outputs 0 immediately. A following i_start reloads from addr 0.
- i_start pulsed mid-load. Expect it ignored, with the address sequence and last address unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//
// Shared definitions for the boot-time instruction-memory loader:
//   XLEN          - core data width in bits
//   IMEM_ADDR_BIT - byte address width of the instruction memory
//   WADDR_W       - word address width seen on the imem write port
//   LANES         - bytes per word
//   LANE_IDX_W    - width of the byte-lane index
//   load_state_t  - loader FSM states
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int XLEN          = 32;
  localparam int IMEM_ADDR_BIT = 12;
  localparam int WADDR_W       = IMEM_ADDR_BIT - 2;
  localparam int LANES         = XLEN / 8;
  localparam int LANE_IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } load_state_t;

  // Index of the most significant byte lane; accepting it completes a word.
  function automatic logic [LANE_IDX_W-1:0] final_lane_idx();
    return LANE_IDX_W'(LANES - 1);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// ---------------------------------------------------------------------------
// imem_word_packer
//
// Collects host bytes into one little-endian word. Byte n of a word lands
// in bits [8n+7:8n]. The loader FSM clears the packer at the start of each
// word and whenever a partial word has to be thrown away.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   clear       in   drop any partial word and restart at lane 0
//   push        in   accept din into the current lane
//   din         in   host byte
//   last_lane   out  the next push completes the word
//   packed_word out  current lanes with din merged into the current lane,
//                    i.e. the word as it will look once din is accepted
// ---------------------------------------------------------------------------
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic [7:0]      din,
  output logic            last_lane,
  output logic [XLEN-1:0] packed_word
);

  logic [LANE_IDX_W-1:0] byte_idx;
  logic [XLEN-1:0]       lanes;
  logic                  word_full;

  // Once all lanes are filled further pushes are refused until the FSM
  // clears the packer, so a stray push can never corrupt a finished word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= '0;
      lanes     <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      byte_idx  <= '0;
      lanes     <= '0;
      word_full <= 1'b0;
    end else if (push && !word_full) begin
      lanes    <= packed_word;
      byte_idx <= byte_idx + 1'b1;
      if (last_lane) begin
        word_full <= 1'b1;
      end
    end
  end

  // The merged word is exposed combinationally so the loader can register
  // the complete word in the same edge that accepts its final byte.
  always_comb begin
    packed_word = lanes;
    packed_word[{byte_idx, 3'b000} +: 8] = din;
  end

  assign last_lane = (byte_idx == final_lane_idx());

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. Takes a byte stream from the host
// link, packs it little-endian into words and writes them to consecutive
// imem word addresses 0..last_addr, holding the core stalled meanwhile.
// A load aborts if the host goes silent for TIMEOUT_CYC cycles.
//
// Parameters:
//   TIMEOUT_CYC  idle cycles tolerated between accepted bytes (>= 2)
//
// Ports:
//   i_clk         in   clock
//   i_rst         in   asynchronous active-high reset
//   i_start       in   start pulse, honoured only when idle
//   i_last_addr   in   last word address to load, sampled with i_start
//   i_byte_valid  in   host byte valid
//   i_byte        in   host byte
//   o_byte_ready  out  loader accepts a byte this cycle
//   o_imem_we     out  imem write enable, one cycle per word
//   o_imem_waddr  out  imem word address
//   o_imem_wdata  out  imem write data
//   o_core_hold   out  core stall request
//   o_busy        out  load in progress
//   o_done        out  one-cycle pulse on successful completion
//   o_err         out  one-cycle pulse on timeout abort
//
// Every output is a register loaded from the next-state decode, so each
// output reflects the state the FSM is in during that cycle.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WADDR_W-1:0] i_last_addr,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte,
  output logic               o_byte_ready,
  output logic               o_imem_we,
  output logic [WADDR_W-1:0] o_imem_waddr,
  output logic [XLEN-1:0]    o_imem_wdata,
  output logic               o_core_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  load_state_t        state, state_n;
  logic [WADDR_W-1:0] last_addr, last_addr_n;
  logic [WADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_n;

  logic               we_n;
  logic [WADDR_W-1:0] waddr_n;
  logic [XLEN-1:0]    wdata_n;
  logic               ready_n;
  logic               busy_n;
  logic               done_n;
  logic               err_n;

  logic               accept;
  logic               pk_clear;
  logic               pk_push;
  logic               pk_last_lane;
  logic [XLEN-1:0]    pk_word;

  imem_word_packer u_packer (
    .clk         (i_clk),
    .rst         (i_rst),
    .clear       (pk_clear),
    .push        (pk_push),
    .din         (i_byte),
    .last_lane   (pk_last_lane),
    .packed_word (pk_word)
  );

  // o_byte_ready is high exactly in RECV, so the handshake alone tells us
  // a byte is being taken this cycle.
  assign accept = o_byte_ready & i_byte_valid;

  // State register plus all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      last_addr    <= '0;
      addr         <= '0;
      idle_cnt     <= '0;
      o_byte_ready <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_waddr <= '0;
      o_imem_wdata <= '0;
      o_core_hold  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_n;
      last_addr    <= last_addr_n;
      addr         <= addr_n;
      idle_cnt     <= idle_cnt_n;
      o_byte_ready <= ready_n;
      o_imem_we    <= we_n;
      o_imem_waddr <= waddr_n;
      o_imem_wdata <= wdata_n;
      o_core_hold  <= busy_n;
      o_busy       <= busy_n;
      o_done       <= done_n;
      o_err        <= err_n;
    end
  end

  // Next-state and next-output decode. The write address/data are loaded
  // on the edge that accepts the final byte of a word, so they are already
  // stable during the single WRITE cycle. An accepted byte takes priority
  // over the timeout, so a byte arriving exactly at the limit still counts.
  always_comb begin
    state_n     = state;
    last_addr_n = last_addr;
    addr_n      = addr;
    idle_cnt_n  = idle_cnt;
    we_n        = 1'b0;
    waddr_n     = o_imem_waddr;
    wdata_n     = o_imem_wdata;
    pk_clear    = 1'b0;
    pk_push     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          last_addr_n = i_last_addr;
          addr_n      = '0;
          idle_cnt_n  = '0;
          pk_clear    = 1'b1;
          state_n     = ST_RECV;
        end
      end

      ST_RECV: begin
        if (accept) begin
          pk_push    = 1'b1;
          idle_cnt_n = '0;
          if (pk_last_lane) begin
            we_n    = 1'b1;
            waddr_n = addr;
            wdata_n = pk_word;
            state_n = ST_WRITE;
          end
        end else if (idle_cnt == CNT_LAST) begin
          pk_clear = 1'b1;
          state_n  = ST_ERR;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end

      ST_WRITE: begin
        if (addr == last_addr) begin
          state_n = ST_DONE;
        end else begin
          addr_n     = addr + 1'b1;
          idle_cnt_n = '0;
          pk_clear   = 1'b1;
          state_n    = ST_RECV;
        end
      end

      ST_DONE: state_n = ST_IDLE;

      ST_ERR: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_RECV);
    busy_n  = (state_n != ST_IDLE);
    done_n  = (state_n == ST_DONE);
    err_n   = (state_n == ST_ERR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed sequence of loads with random byte contents and host gaps.
// Expected words, addresses and pulse timing come from a byte-stream model:
// word k is bytes 4k..4k+3 summed with weights 1, 2^8, 2^16, 2^24.
// ---------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int TO    = 8;
  localparam int DEPTH = 1 << WADDR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic [WADDR_W-1:0] i_last_addr;
  logic               i_byte_valid;
  logic [7:0]         i_byte;
  logic               o_byte_ready;
  logic               o_imem_we;
  logic [WADDR_W-1:0] o_imem_waddr;
  logic [XLEN-1:0]    o_imem_wdata;
  logic               o_core_hold;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  imem_loader #(.TIMEOUT_CYC(TO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_last_addr  (i_last_addr),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_waddr (o_imem_waddr),
    .o_imem_wdata (o_imem_wdata),
    .o_core_hold  (o_core_hold),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [XLEN-1:0]    data;
    int                 cyc;
  } wr_rec_t;

  // Write/done/err observations plus a bench-side copy of the imem that the
  // write port fills, standing in for instr_mem.
  wr_rec_t         wr_q[$];
  int              done_q[$];
  int              err_q[$];
  logic [XLEN-1:0] imem [0:DEPTH-1];

  always @(negedge clk) begin
    if (o_imem_we) begin
      wr_q.push_back('{addr: o_imem_waddr, data: o_imem_wdata, cyc: cyc});
      imem[o_imem_waddr] = o_imem_wdata;
    end
    if (o_done) done_q.push_back(cyc);
    if (o_err)  err_q.push_back(cyc);
  end

  int         total = 0;
  int         bad   = 0;
  int         start_cyc;
  int         idle_cyc;
  int         wr_base, done_base, err_base;
  logic [7:0] bytes_q[$];
  int         acc_q[$];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_word(input int k);
    logic [XLEN-1:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++) begin
      w = w + (XLEN'(bytes_q[LANES*k+j]) << (8*j));
    end
    return w;
  endfunction

  // Offer one byte until the loader takes it, then stay silent for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    int   c;
    bit   ok;
    ok = 1'b0;
    i_byte_valid = 1'b1;
    i_byte       = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      r = o_byte_ready;
      c = cyc;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        acc_q.push_back(c);
      end
    end
    check_output("byte_accepted", 64'(ok), 64'd1);
    i_byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (!o_core_hold) begin
        seen     = 1'b1;
        idle_cyc = cyc;
        check_output("busy_low_when_idle", 64'(o_busy), 64'd0);
      end
    end
    check_output("idle_reached", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input int last, input int nbytes);
    wr_base   = wr_q.size();
    done_base = done_q.size();
    err_base  = err_q.size();
    bytes_q.delete();
    acc_q.delete();
    for (int i = 0; i < nbytes; i++) bytes_q.push_back(8'($urandom));
    @(posedge clk);
    #1;
    // The first byte is offered together with i_start; it must not be taken
    // in that cycle.
    i_start      = 1'b1;
    i_last_addr  = WADDR_W'(last);
    i_byte_valid = 1'b1;
    i_byte       = bytes_q[0];
    @(negedge clk);
    start_cyc = cyc;
    check_output("ready_low_in_start_cycle", 64'(o_byte_ready), 64'd0);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // mid_start >= 0 pulses i_start (with a different last address) just
  // before that byte index.
  task automatic apply_stimulus(input int last, input int nbytes, input int maxgap,
                                input int mingap, input int mid_start);
    int gap;
    begin_load(last, nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (i == mid_start) begin
        i_start     = 1'b1;
        i_last_addr = '0;
        @(posedge clk);
        #1;
        i_start = 1'b0;
      end
      gap = (i == nbytes - 1) ? 0 : int'($urandom_range(maxgap, mingap));
      send_byte(bytes_q[i], gap);
    end
    i_byte_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_load(input int last, input int nbytes, input bit full_rate);
    int      words, exp_writes, nwr, ndone, nerr, end_cyc;
    bit      expect_done;
    wr_rec_t w;
    words       = last + 1;
    expect_done = (nbytes >= LANES * words);
    exp_writes  = expect_done ? words : nbytes / LANES;
    nwr         = wr_q.size() - wr_base;
    ndone       = done_q.size() - done_base;
    nerr        = err_q.size() - err_base;
    end_cyc     = -1;
    check_output("write_count", 64'(nwr), 64'(exp_writes));
    check_output("first_accept_cycle", 64'(acc_q[0]), 64'(start_cyc + 1));
    for (int k = 0; k < nwr && k < exp_writes; k++) begin
      w = wr_q[wr_base+k];
      check_output("write_addr", 64'(w.addr), 64'(k));
      check_output("write_data", 64'(w.data), 64'(model_word(k)));
      check_output("imem_word", 64'(imem[k]), 64'(model_word(k)));
      check_output("write_cycle", 64'(w.cyc), 64'(acc_q[LANES*k+LANES-1] + 1));
      if (full_rate && k > 0) begin
        check_output("write_spacing", 64'(w.cyc - wr_q[wr_base+k-1].cyc), 64'd5);
      end
    end
    if (expect_done) begin
      check_output("done_count", 64'(ndone), 64'd1);
      check_output("err_count", 64'(nerr), 64'd0);
      if (ndone > 0 && nwr > 0) begin
        check_output("done_cycle", 64'(done_q[done_base]), 64'(wr_q[wr_q.size()-1].cyc + 1));
        end_cyc = done_q[done_base];
      end
    end else begin
      check_output("err_count", 64'(nerr), 64'd1);
      check_output("done_count", 64'(ndone), 64'd0);
      if (nerr > 0) begin
        check_output("err_cycle", 64'(err_q[err_base]), 64'(acc_q[acc_q.size()-1] + 1 + TO));
        end_cyc = err_q[err_base];
      end
    end
    if (end_cyc >= 0) begin
      check_output("hold_drop_cycle", 64'(idle_cyc), 64'(end_cyc + 1));
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({o_byte_ready, o_imem_we, o_imem_waddr, o_imem_wdata,
                o_core_hold, o_busy, o_done, o_err});
  endfunction

  initial begin
    int last;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_last_addr  = '0;
    i_byte_valid = 1'b0;
    i_byte       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single word at address 0 with a fixed instruction.
    begin_load(0, 4);
    bytes_q[0] = 8'h13; bytes_q[1] = 8'h00; bytes_q[2] = 8'h00; bytes_q[3] = 8'h00;
    i_byte = 8'h13;
    for (int i = 0; i < 4; i++) send_byte(bytes_q[i], 0);
    wait_idle();
    check_load(0, 4, 1'b1);
    check_output("single_word_value", 64'(imem[0]), 64'h13);

    // Four words back-to-back at full host rate.
    apply_stimulus(3, 16, 0, 0, -1);
    check_load(3, 16, 1'b1);

    // Host stalls two cycles between bytes.
    apply_stimulus(3, 16, 2, 2, -1);
    check_load(3, 16, 1'b0);

    // Longest tolerated silence between bytes.
    apply_stimulus(1, 8, TO - 1, TO - 1, -1);
    check_load(1, 8, 1'b0);

    // Timeout after two bytes: nothing written.
    apply_stimulus(0, 2, 0, 0, -1);
    check_load(0, 2, 1'b0);

    // Timeout mid second word: first word stays, partial word dropped.
    apply_stimulus(3, 6, 0, 0, -1);
    check_load(3, 6, 1'b0);

    // i_start pulsed during a load is ignored.
    apply_stimulus(3, 16, 1, 0, 6);
    check_load(3, 16, 1'b0);

    // Reset during the WRITE cycle of word 1 of 3.
    begin_load(2, 12);
    for (int i = 0; i < 8; i++) send_byte(bytes_q[i], 0);
    check_output("we_before_reset", 64'(o_imem_we), 64'd1);
    rst = 1'b1;
    #1;
    check_output("outputs_on_async_reset", all_outputs(), 64'd0);
    @(negedge clk);
    check_output("writes_before_reset", 64'(wr_q.size() - wr_base), 64'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(2, 12, 0, 0, -1);
    check_load(2, 12, 1'b1);

    // Random word counts and host gaps.
    for (int r = 0; r < 4; r++) begin
      last = int'($urandom_range(4, 0));
      apply_stimulus(last, LANES * (last + 1), 3, 0, -1);
      check_load(last, LANES * (last + 1), 1'b0);
    end

    // Full imem depth.
    apply_stimulus(DEPTH - 1, LANES * DEPTH, 0, 0, -1);
    check_load(DEPTH - 1, LANES * DEPTH, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
